// File: rtl/switch_pkg.sv
// Shared types and constants for the switch core egress scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package switch_pkg;

    // Number of queue controllers / output ports (fixed at 4 in this revision).
    localparam int NPORT = 4;

    // Width of each per-port weight field in cfg_weight.
    localparam int WW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/rr_pick4.sv
// Rotating priority encoder over four requesters: scans start, start+1, ... modulo 4.
// Latency: purely combinational.
// Backpressure: none; req already carries eligibility.
// Ports: req - request vector; start - first index to scan;
//        gnt_idx - first requesting index at or after start; gnt_any - any request present.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] start,
    output logic [1:0] gnt_idx,
    output logic       gnt_any
);

    logic [1:0] scan_idx;
    logic       found;

    always_comb begin
        gnt_idx  = start;
        gnt_any  = |req;
        found    = 1'b0;
        scan_idx = start;
        for (int k = 0; k < 4; k++) begin
            scan_idx = start + 2'(k);
            if (!found && req[scan_idx]) begin
                gnt_idx = scan_idx;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_egress_sched.sv
// Weighted round-robin cell scheduler for the shared packet SRAM read port.
// Latency: eligibility sampled in IDLE at cycle N gives ptr_ack during cycle N+1.
// Backpressure: o_cell_bp masks a port at selection time only; the block holds in WAIT until cell_done.
// Ports: clk/rstn - clock and async active-low reset; ptr_rdy - head pointer available per port;
//        o_cell_bp - output FIFO full per port; cfg_weight - 4-bit burst weight per port (0 masks);
//        cell_done - read engine end-of-cell pulse; ptr_ack - one-hot grant pulse;
//        sched_port - last granted port; sched_busy - cell in flight.
module switch_egress_sched #(
    parameter int NPORT = 4,
    parameter int WW    = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NPORT-1:0]    ptr_rdy,
    input  logic [NPORT-1:0]    o_cell_bp,
    input  logic [NPORT*WW-1:0] cfg_weight,
    input  logic                cell_done,
    output logic [NPORT-1:0]    ptr_ack,
    output logic [1:0]          sched_port,
    output logic                sched_busy
);

    import switch_pkg::*;

    sched_state_t    state_q, state_d;
    logic [1:0]      last_q, last_d;
    logic [1:0]      port_q, port_d;
    logic [WW-1:0]   burst_q, burst_d;

    logic [NPORT-1:0] elig;
    logic [1:0]       rot_idx;
    logic             rot_any;
    logic [WW-1:0]    rot_weight;
    logic             cont;

    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            elig[i] = ptr_rdy[i] & ~o_cell_bp[i] & (cfg_weight[i*WW +: WW] != '0);
        end
    end

    // Scan starts just after the last granted port, so a lone eligible last
    // port is found again only after every other port has been passed over.
    rr_pick4 u_pick (
        .req     (elig),
        .start   (last_q + 2'd1),
        .gnt_idx (rot_idx),
        .gnt_any (rot_any)
    );

    always_comb begin
        rot_weight = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (rot_idx == 2'(i)) begin
                rot_weight = cfg_weight[i*WW +: WW];
            end
        end
    end

    // Keep serving the current port while its burst has credit left.
    assign cont = (burst_q != '0) && elig[last_q];

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        port_d  = port_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                if (cont) begin
                    state_d = GRANT;
                    port_d  = last_q;
                    burst_d = burst_q - WW'(1);
                end else if (rot_any) begin
                    // rot_idx is eligible, so its weight is non-zero and the reload cannot underflow.
                    state_d = GRANT;
                    last_d  = rot_idx;
                    port_d  = rot_idx;
                    burst_d = rot_weight - WW'(1);
                end
            end
            GRANT: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (cell_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            port_q  <= 2'd0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            port_q  <= port_d;
            burst_q <= burst_d;
        end
    end

    // Outputs decode registered state only; last_q holds the chosen port throughout GRANT.
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            ptr_ack[i] = (state_q == GRANT) && (last_q == 2'(i));
        end
    end

    assign sched_port = port_q;
    assign sched_busy = (state_q != IDLE);

endmodule

// File: tb/tb_switch_egress_sched.sv
module tb_switch_egress_sched;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  ptr_rdy = 4'b0;
    logic [3:0]  o_cell_bp = 4'b0;
    logic [15:0] cfg_weight = 16'h1111;
    logic        cell_done = 1'b0;
    logic [3:0]  ptr_ack;
    logic [1:0]  sched_port;
    logic        sched_busy;

    switch_egress_sched #(.NPORT(4), .WW(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .ptr_rdy    (ptr_rdy),
        .o_cell_bp  (o_cell_bp),
        .cfg_weight (cfg_weight),
        .cell_done  (cell_done),
        .ptr_ack    (ptr_ack),
        .sched_port (sched_port),
        .sched_busy (sched_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int glog[$];
    int gcyc[$];
    int exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per-port credit left in the current burst, the port last served,
    // and whether a cell is outstanding (ack pulse first, then waiting for done).
    int m_last, m_left, m_port, m_ch;
    bit m_busy, m_ack;

    function automatic bit m_elig(input int p);
        return ptr_rdy[p] && !o_cell_bp[p] && (cfg_weight[p*4 +: 4] != 4'd0);
    endfunction

    function automatic int m_wt(input int p);
        return int'(cfg_weight[p*4 +: 4]);
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_last = 3; m_left = 0; m_port = 0; m_busy = 0; m_ack = 0;
        end else if (!m_busy) begin
            m_ch = -1;
            if (m_left > 0 && m_elig(m_last)) begin
                m_ch = m_last;
                m_left = m_left - 1;
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    if (m_ch < 0 && m_elig((m_last + k) % 4)) begin
                        m_ch = (m_last + k) % 4;
                        m_left = m_wt(m_ch) - 1;
                    end
                end
            end
            if (m_ch >= 0) begin
                m_last = m_ch; m_port = m_ch; m_busy = 1; m_ack = 1;
            end
        end else if (m_ack) begin
            m_ack = 0;
        end else if (cell_done) begin
            m_busy = 0;
        end
    end

    // Per-cycle comparison against the model, plus a grant log for hand-computed sequences.
    always @(negedge clk) begin
        cyc++;
        chk("ptr_ack", 32'(ptr_ack), m_ack ? (32'd1 << m_port) : 32'd0);
        chk("sched_port", 32'(sched_port), 32'(m_port));
        chk("sched_busy", 32'(sched_busy), 32'(m_busy));
        for (int i = 0; i < 4; i++) begin
            if (ptr_ack[i]) begin
                glog.push_back(i);
                gcyc.push_back(cyc);
            end
        end
    end

    task automatic check_log(input string name);
        chk({name, "_len"}, 32'(glog.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < glog.size()) chk({name, "_grant"}, 32'(glog[i]), 32'(exp_q[i]));
        end
        glog.delete();
        gcyc.delete();
    endtask

    task automatic check_gap(input string name, input int exp);
        if (gcyc.size() < 2) chk(name, 32'd0, 32'(exp));
        else chk(name, 32'(gcyc[1] - gcyc[0]), 32'(exp));
    endtask

    task automatic wait_ack(output bit ok);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (ptr_ack == 4'b0 && t < 30);
        ok = (ptr_ack != 4'b0);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout actual=none expected=grant at %0t", $time);
        end
    endtask

    task automatic pulse_done();
        @(posedge clk); #2 cell_done = 1'b1;
        @(posedge clk); #2 cell_done = 1'b0;
    endtask

    task automatic run_grants(input int n, input int dly);
        bit ok;
        for (int i = 0; i < n; i++) begin
            wait_ack(ok);
            if (!ok) return;
            repeat (dly) @(posedge clk);
            pulse_done();
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #3 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        glog.delete();
        gcyc.delete();
    endtask

    initial begin
        bit ok;

        // Reset state and priority after reset.
        ptr_rdy = 4'b1111; cfg_weight = 16'h1111;
        @(negedge clk);
        chk("rst_ack", 32'(ptr_ack), 32'd0);
        chk("rst_port", 32'(sched_port), 32'd0);
        chk("rst_busy", 32'(sched_busy), 32'd0);
        @(posedge clk); #2 rstn = 1'b1;
        run_grants(5, 0);
        check_gap("min_spacing", 3);
        exp_q = {0, 1, 2, 3, 0};
        check_log("prio");

        // Weighted burst p0=3 p1=1 p2=0 p3=2 with a 4-beat read engine.
        cfg_weight = 16'h2013;
        do_reset();
        run_grants(7, 3);
        check_gap("period", 6);
        exp_q = {0, 0, 0, 1, 3, 3, 0};
        check_log("weighted");

        // Backpressure mid-burst on p0 (weight 4).
        cfg_weight = 16'h1114;
        do_reset();
        run_grants(1, 0);
        o_cell_bp = 4'b0001;
        run_grants(3, 0);
        o_cell_bp = 4'b0000;
        run_grants(5, 0);
        exp_q = {0, 1, 2, 3, 0, 0, 0, 0, 1};
        check_log("backpressure");

        // Single eligible port p2 with weight 2; one-cycle grant latency.
        ptr_rdy = 4'b0000; cfg_weight = 16'h1211;
        do_reset();
        repeat (3) @(posedge clk);
        #2 ptr_rdy = 4'b0100;
        @(negedge clk);
        chk("lat_before", 32'(ptr_ack), 32'd0);
        @(negedge clk);
        chk("lat_ack", 32'(ptr_ack), 32'd4);
        pulse_done();
        run_grants(3, 1);
        exp_q = {2, 2, 2, 2};
        check_log("single");

        // Stray cell_done in IDLE, then held-off cell_done in WAIT.
        ptr_rdy = 4'b0000; cfg_weight = 16'h1111;
        do_reset();
        pulse_done();
        @(negedge clk);
        chk("stray_busy", 32'(sched_busy), 32'd0);
        chk("stray_ack", 32'(ptr_ack), 32'd0);
        @(posedge clk); #2 ptr_rdy = 4'b0010;
        wait_ack(ok);
        repeat (10) begin
            @(negedge clk);
            chk("held_busy", 32'(sched_busy), 32'd1);
            chk("held_ack", 32'(ptr_ack), 32'd0);
        end
        pulse_done();
        @(negedge clk);
        chk("done_busy", 32'(sched_busy), 32'd0);
        run_grants(1, 0);
        exp_q = {1, 1};
        check_log("held");

        // Asynchronous reset while waiting on a cell.
        ptr_rdy = 4'b1111; cfg_weight = 16'h1111;
        do_reset();
        run_grants(1, 0);
        wait_ack(ok);
        @(posedge clk);
        @(posedge clk); #3 rstn = 1'b0;
        #1;
        chk("arst_ack", 32'(ptr_ack), 32'd0);
        chk("arst_busy", 32'(sched_busy), 32'd0);
        chk("arst_port", 32'(sched_port), 32'd0);
        @(posedge clk); #2 rstn = 1'b1;
        run_grants(1, 0);
        exp_q = {0, 1, 0};
        check_log("arst");

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
